alu_seq_ctrl: RTL and testbench

- Parametrised control-path sequencer for the multi-operand ALU datapath.
- On `start` it:
  - validates and latches an opcode;
  - loads N_OPS operands one at a time through a valid/ready handshake;
  - issues a one-cycle execute pulse, then waits for datapath `done`, with a timeout;
  - strobes the result register and holds `finish` until acknowledged.
- Successor to the fixed two-operand controller: adds variable operand count, input back-pressure, illegal-opcode rejection, done timeout and an error flag.

---
 rtl/alu_seq_ctrl.sv | 130 +++++++++++++
 tb/tb_alu_seq_ctrl.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/alu_seq_ctrl.sv
// Control-path sequencer for the multi-operand ALU datapath: opcode check, operand
// loading with back-pressure, execute pulse, done wait with timeout, result strobe.
module alu_seq_ctrl #(
    parameter int                   N_OPS    = 2,
    parameter int                   OPW      = 2,
    parameter logic [2**OPW-1:0]    OP_LEGAL = 4'b1111,
    parameter int                   TMO      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [OPW-1:0]   op_code,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [N_OPS-1:0] ld_op,
    output logic [OPW-1:0]   op_sel,
    output logic             go,
    input  logic             done,
    output logic             ld_res,
    output logic             busy,
    output logic             finish,
    output logic             err,
    input  logic             ack
);
    // state  | meaning
    // S_IDLE | waiting for start, opcode checked on acceptance
    // S_LOAD | loading operand idx whenever in_valid is high
    // S_EXEC | one-cycle go pulse, timeout counter cleared
    // S_WAIT | waiting for done, bounded by TMO cycles
    // S_RES  | one-cycle result register load
    // S_FIN  | finish held (err valid) until ack

    localparam int IDXW = (N_OPS > 1) ? $clog2(N_OPS) : 1;
    localparam int CW   = (TMO > 1) ? $clog2(TMO) : 1;
    localparam logic [IDXW-1:0] IDX_LAST = IDXW'(N_OPS - 1);
    localparam logic [CW-1:0]   CNT_LAST = CW'(TMO - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_EXEC,
        S_WAIT,
        S_RES,
        S_FIN
    } state_t;

    state_t          state, state_nxt;
    logic [IDXW-1:0] idx, idx_nxt;
    logic [CW-1:0]   cnt, cnt_nxt;
    logic [OPW-1:0]  op_q, op_nxt;
    logic            err_q, err_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            idx   <= '0;
            cnt   <= '0;
            op_q  <= '0;
            err_q <= 1'b0;
        end else begin
            state <= state_nxt;
            idx   <= idx_nxt;
            cnt   <= cnt_nxt;
            op_q  <= op_nxt;
            err_q <= err_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        cnt_nxt   = cnt;
        op_nxt    = op_q;
        err_nxt   = err_q;
        case (state)
            S_IDLE: begin
                if (start) begin
                    if (OP_LEGAL[op_code]) begin
                        op_nxt    = op_code;
                        idx_nxt   = '0;
                        state_nxt = S_LOAD;
                    end else begin
                        // rejected opcode skips the datapath entirely
                        err_nxt   = 1'b1;
                        state_nxt = S_FIN;
                    end
                end
            end
            S_LOAD: begin
                if (in_valid) begin
                    if (idx == IDX_LAST) state_nxt = S_EXEC;
                    else                 idx_nxt   = idx + 1'b1;
                end
            end
            S_EXEC: begin
                cnt_nxt   = '0;
                state_nxt = S_WAIT;
            end
            S_WAIT: begin
                // done wins over the terminal count, so the last WAIT cycle still completes
                if (done) begin
                    state_nxt = S_RES;
                end else if (cnt == CNT_LAST) begin
                    err_nxt   = 1'b1;
                    state_nxt = S_FIN;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            S_RES: state_nxt = S_FIN;
            S_FIN: begin
                if (ack) begin
                    err_nxt   = 1'b0;
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    assign busy     = (state != S_IDLE);
    assign in_ready = (state == S_LOAD);
    assign go       = (state == S_EXEC);
    assign ld_res   = (state == S_RES);
    assign finish   = (state == S_FIN);
    assign err      = err_q;
    assign op_sel   = op_q;
    assign ld_op    = (in_ready && in_valid) ? (N_OPS'(1) << idx) : '0;

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Self-checking bench for alu_seq_ctrl: per-operation timestamp model derived from
// the operand/done/ack stimulus, checked every cycle against all outputs.
module tb_alu_seq_ctrl;
    localparam int N   = 4;
    localparam int OPW = 2;
    localparam int TMO = 16;
    localparam logic [3:0] LEG = 4'b0111;

    logic           clk = 1'b0;
    logic           rst, start, in_valid, done, ack;
    logic [OPW-1:0] op_code;
    logic           in_ready, go, ld_res, busy, finish, err;
    logic [N-1:0]   ld_op;
    logic [OPW-1:0] op_sel;

    int checks   = 0;
    int failures = 0;
    logic [OPW-1:0] last_op;
    logic [3:0]     leg_v;

    alu_seq_ctrl #(.N_OPS(N), .OPW(OPW), .OP_LEGAL(LEG), .TMO(TMO)) dut (
        .clk(clk), .rst(rst), .start(start), .op_code(op_code),
        .in_valid(in_valid), .in_ready(in_ready), .ld_op(ld_op), .op_sel(op_sel),
        .go(go), .done(done), .ld_res(ld_res), .busy(busy), .finish(finish),
        .err(err), .ack(ack)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s t=%0t observed=%0h expected=%0h", tag, $time, obs, exp);
        end
    endtask

    task automatic check_outs(input logic e_busy, input logic e_rdy, input logic [N-1:0] e_ld,
                              input logic e_go, input logic e_res, input logic e_fin,
                              input logic e_err, input logic [OPW-1:0] e_op);
        chk("busy",     32'(busy),     32'(e_busy));
        chk("in_ready", 32'(in_ready), 32'(e_rdy));
        chk("ld_op",    32'(ld_op),    32'(e_ld));
        chk("go",       32'(go),       32'(e_go));
        chk("ld_res",   32'(ld_res),   32'(e_res));
        chk("finish",   32'(finish),   32'(e_fin));
        chk("err",      32'(err),      32'(e_err));
        chk("op_sel",   32'(op_sel),   32'(e_op));
    endtask

    // One full operation. Period 0 drives start in IDLE; each later period is one
    // clock. vmode: 0 = in_valid always 1, 1 = 3-cycle gap after two loads, 2 = random.
    // d: WAIT cycle on which done rises (>= TMO means never). a: extra FIN cycles before ack.
    task automatic run_op(input logic [OPW-1:0] op, input int vmode, input int d, input int a);
        bit vp[160];
        int lc[N];
        int k, t_last, t_go, t_res, t_fin, t_ack, t_wend;
        bit legal, e_err;
        logic [OPW-1:0] op_e;
        logic [N-1:0] e_ld;
        for (int p = 0; p < 160; p++) begin
            case (vmode)
                0:       vp[p] = 1'b1;
                1:       vp[p] = !(p >= 3 && p <= 5);
                default: vp[p] = (p > 40) ? 1'b1 : ($urandom_range(0, 9) < 6);
            endcase
        end
        for (int j = 0; j < N; j++) lc[j] = -1;
        legal = leg_v[op];
        if (legal) begin
            k = 0;
            for (int p = 1; k < N; p++) begin
                if (vp[p]) begin
                    lc[k] = p;
                    k++;
                end
            end
            t_last = lc[N-1];
            t_go   = t_last + 1;
            if (d < TMO) begin
                t_res  = t_go + 2 + d;
                t_fin  = t_res + 1;
                t_wend = t_res;
                e_err  = 1'b0;
            end else begin
                t_res  = -1;
                t_fin  = t_go + 1 + TMO;
                t_wend = t_fin;
                e_err  = 1'b1;
            end
            op_e = op;
        end else begin
            t_last = 0;
            t_go   = -1;
            t_res  = -1;
            t_fin  = 1;
            t_wend = -1;
            e_err  = 1'b1;
            op_e   = last_op;
        end
        t_ack = t_fin + a;
        for (int p = 0; p <= t_ack; p++) begin
            @(negedge clk);
            start    = (p == 0 || p == t_ack) ? 1'b1 : 1'($urandom_range(0, 1));
            op_code  = (p == 0) ? op : OPW'($urandom_range(0, 3));
            in_valid = vp[p];
            ack      = (p == t_ack);
            if (legal && p > t_go && p < t_wend) done = (p == t_go + 1 + d);
            else                                 done = 1'($urandom_range(0, 1));
            #1;
            e_ld = '0;
            for (int j = 0; j < N; j++) if (legal && lc[j] == p) e_ld = N'(1) << j;
            check_outs(p >= 1, legal && p >= 1 && p <= t_last, e_ld,
                       p == t_go, p == t_res, p >= t_fin, (p >= t_fin) && e_err,
                       (p == 0) ? last_op : op_e);
        end
        last_op = op_e;
    endtask

    task automatic idle_check();
        @(negedge clk);
        start = 1'b0; ack = 1'b0; done = 1'b1; in_valid = 1'b1;
        #1;
        check_outs(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, last_op);
    endtask

    initial begin
        leg_v    = LEG;
        last_op  = '0;
        rst      = 1'b1;
        start    = 1'b0;
        op_code  = '0;
        in_valid = 1'b0;
        done     = 1'b0;
        ack      = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_outs(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00);

        run_op(2'b01, 0, 0, 0);       // back-to-back loads, done in first WAIT cycle
        run_op(2'b10, 1, 3, 2);       // operand stall, later done, delayed ack
        run_op(2'b11, 2, 0, 1);       // illegal opcode
        run_op(2'b00, 0, TMO, 0);     // timeout
        run_op(2'b01, 2, TMO - 1, 1); // done on the last permitted WAIT cycle

        // reset while in WAIT: start accepted, 4 loads, go, then rst on WAIT cycle 2
        @(negedge clk);
        start = 1'b1; op_code = 2'b10; in_valid = 1'b1; done = 1'b0; ack = 1'b0;
        for (int p = 1; p <= N + 3; p++) begin
            @(negedge clk);
            start = 1'b0;
        end
        #1;
        chk("rst_pre_busy", 32'(busy), 32'd1);
        chk("rst_pre_opsel", 32'(op_sel), 32'd2);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; start = 1'b0; done = 1'b1; ack = 1'b1; in_valid = 1'b1;
        #1;
        last_op = '0;
        check_outs(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00);
        ack = 1'b0;
        run_op(2'b10, 0, 0, 0);

        for (int i = 0; i < 25; i++) begin
            run_op(OPW'($urandom_range(0, 3)), 2,
                   ($urandom_range(0, 5) == 0) ? TMO : int'($urandom_range(0, TMO - 1)),
                   int'($urandom_range(0, 3)));
        end
        idle_check();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
